key_cmd_tx: RTL and testbench
=============================

Name: key_cmd_tx

Overview:
- Transmit side of the calculator's serial unlock/mode-key protocol.
- Serializes the 4-bit unlock key plus a mode bit onto the one-bit key line and its command-valid strobe, then issues the extra verify slot the receiving decoder consumes.
- Once the unlock completes, sends single-slot mode updates on request.
- Sits between the front-end control logic and the key decoder on the calculator datapath.

Parameters:
- KEY_W, 4: unlock key width in bits.
- KEY_VAL, 4'b1010: unlock key value, sent MSB first.
- GAP, 2: idle cycles inserted after each valid slot. Used only when KEYTX_PACING_EN is defined. Legal range 1..15.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request to send the unlock sequence. Level-sampled; accepted only in IDLE.
- ModeReq  input  1  mode bit to transmit. Sampled when Start or ModeUpd is accepted.
- ModeUpd  input  1  request to send one mode-update slot. Accepted only in UNLOCKED.
- TxBit  output  1  serial data; drives the decoder's InputKey.
- TxValid  output  1  slot strobe; drives the decoder's ValidCmd.
- Busy  output  1  high while a sequence or update is in progress.
- Unlocked  output  1  high once the unlock sequence has completed.
- Done  output  1  one-cycle pulse when a sequence or update completes.

Behaviour:
- Reset is asynchronous.
  - All outputs go to 0; state goes to IDLE; shift register and counters clear.
  - Reset asserted mid-sequence aborts with no further TxValid. The decoder shares the same Reset, so both ends return to the start together.
- FSM states: IDLE, SEND, VERIFY, UNLOCKED, UPDATE (plus GAP when paced).
- IDLE:
  - Start=1 at edge N: latch the shift register {KEY_VAL, ModeReq}, clear the bit counter, enter SEND. Busy=1 from cycle N+1.
  - ModeUpd is ignored in IDLE.
  - If Start and ModeUpd are both high, Start wins.
- SEND:
  - One slot per cycle: TxValid=1 and TxBit = shift register MSB; shift left.
  - Slots 0..KEY_W-1 carry the key, MSB first. Slot KEY_W carries the mode bit.
  - After slot KEY_W, go to VERIFY.
- VERIFY:
  - One slot with TxValid=1 and TxBit=0. The decoder ignores the data in this slot.
  - Next state is UNLOCKED. In that cycle Unlocked=1, Done=1 for one cycle, Busy=0.
- Unpaced timing with Start accepted at edge N:
  - Data slots occupy cycles N+1..N+5.
  - Verify slot is cycle N+6.
  - Done and Unlocked rise at cycle N+7.
- UNLOCKED:
  - Start is ignored, since re-sending the key would corrupt the decoder's Mode.
  - ModeUpd=1: latch ModeReq and enter UPDATE.
- UPDATE:
  - One slot with TxValid=1 and TxBit = latched mode.
  - Then return to UNLOCKED with Done=1 for one cycle.
  - Busy=1 only during the UPDATE cycle.
  - ModeUpd held continuously produces back-to-back updates, one every 2 cycles.
- TxValid is never high outside the SEND, VERIFY and UPDATE slots.
- TxBit is held at its last value when TxValid=0.
- Unlocked stays high until Reset; there is no software lock.
- Outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: KEYTX_PACING_EN.
- Defined:
  - Every valid slot (SEND, VERIFY, UPDATE) is followed by GAP cycles with TxValid=0 and TxBit held.
  - A 4-bit gap counter runs in the GAP state; the FSM then resumes its next slot.
  - Slot k of the unlock sequence lands at cycle N+1+k*(GAP+1).
  - Done fires after the final gap.
  - Busy stays high through the gaps.
- Undefined: slots are back-to-back; the GAP state and counter are not built.

Decomposition:
- Package key_tx_pkg holds:
  - KEY_W and KEY_VAL defaults;
  - the state enum typedef;
  - the mode-bit slot index localparam (KEY_W).
- One natural sub-module, keytx_pacer: the gap counter, instantiated only under KEYTX_PACING_EN. It takes a start pulse and reports gap done.
- Shift register and FSM stay in key_cmd_tx.

Test Plan:
1. Unpaced unlock: Start=1, ModeReq=1 at edge N.
   - Slots N+1..N+5 carry TxBit 1,0,1,0,1 with TxValid=1.
   - N+6: TxValid=1, TxBit=0.
   - N+7: Done=1, Unlocked=1.
   - A decoder model reports Active=1, Mode=1.
2. Mode update: in UNLOCKED, ModeUpd=1 with ModeReq=0.
   - One TxValid slot with TxBit=0, then Done pulse.
   - Decoder Mode=0.
   - Start pulses in UNLOCKED produce no TxValid.
3. Ignored requests:
   - Start re-asserted during SEND changes no slot.
   - Start and ModeUpd together in IDLE start the unlock sequence.
   - ModeUpd in IDLE produces no TxValid.
4. Reset mid-sequence: Reset asserted after slot 2.
   - All outputs 0 immediately; no further TxValid.
   - A new Start after release produces a full 6-slot sequence.
5. Paced (KEYTX_PACING_EN, GAP=2): Start at edge N.
   - TxValid high only at N+1, N+4, N+7, N+10, N+13, N+16.
   - Done at N+19.
6. Continuous ModeUpd with alternating ModeReq.
   - Slots every 2 cycles (every GAP+2 cycles when paced).
   - Decoder Mode tracks each sent bit.

Source files
------------

// File: rtl/key_tx_pkg.sv
// ============================================================================
// key_tx_pkg : shared constants and state encoding for the key/mode transmitter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package key_tx_pkg;

  localparam int                    KEY_W_DEF   = 4;
  localparam logic [KEY_W_DEF-1:0]  KEY_VAL_DEF = 4'b1010;

  // Slot index that carries the mode bit, directly after the key bits
  localparam int                    MODE_SLOT   = KEY_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_VERIFY   = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_UPDATE   = 3'd4,
    ST_GAP      = 3'd5
  } key_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/keytx_pacer.sv
// ============================================================================
// keytx_pacer : idle-gap counter placed after each valid slot (KEYTX_PACING_EN)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module keytx_pacer #(
  parameter int GAP = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start_i,
  output logic gap_done_o
);

  logic [3:0] cnt_q, cnt_d;

  // Loaded during the slot cycle so the count reaches zero in the last gap cycle
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 4'(GAP - 1);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gap_done_o = (cnt_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/key_cmd_tx.sv
// ============================================================================
// key_cmd_tx : serial unlock-key / mode-update transmitter for the key decoder
//              optional inter-slot gaps when KEYTX_PACING_EN is defined
// Revision   : 1.0
// ============================================================================
`default_nettype none

module key_cmd_tx
  import key_tx_pkg::*;
#(
  parameter int               KEY_W   = KEY_W_DEF,
  parameter logic [KEY_W-1:0] KEY_VAL = KEY_VAL_DEF
`ifdef KEYTX_PACING_EN
  ,
  parameter int               GAP     = 2
`endif
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic ModeReq,
  input  logic ModeUpd,
  output logic TxBit,
  output logic TxValid,
  output logic Busy,
  output logic Unlocked,
  output logic Done
);

  localparam int SH_W  = KEY_W + 1;
  localparam int CNT_W = $clog2(KEY_W + 1);

  key_tx_state_e   state_q, state_d;
  logic [SH_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            tx_bit_q, tx_bit_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            unlocked_q, unlocked_d;
  logic            done_q, done_d;
  logic            go_send, go_verify, go_done;
  logic            last_data_slot;

`ifdef KEYTX_PACING_EN
  key_tx_state_e   ret_q, ret_d;
  logic            gap_done;

  keytx_pacer #(
    .GAP        (GAP)
  ) u_pacer (
    .Clk        (Clk),
    .Reset      (Reset),
    .start_i    (tx_valid_q),
    .gap_done_o (gap_done)
  );
`endif

  assign last_data_slot = (cnt_q == CNT_W'(KEY_W));

  // Outputs are computed for the next cycle and registered alongside the state
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = 1'b0;
    unlocked_d = unlocked_q;
    done_d     = 1'b0;
    go_send    = 1'b0;
    go_verify  = 1'b0;
    go_done    = 1'b0;
`ifdef KEYTX_PACING_EN
    ret_d      = ret_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d    = ST_SEND;
          shift_d    = {KEY_VAL, ModeReq};
          cnt_d      = '0;
          tx_bit_d   = KEY_VAL[KEY_W-1];
          tx_valid_d = 1'b1;
        end
      end
      ST_SEND: begin
`ifdef KEYTX_PACING_EN
        state_d = ST_GAP;
        ret_d   = last_data_slot ? ST_VERIFY : ST_SEND;
`else
        go_verify = last_data_slot;
        go_send   = !last_data_slot;
`endif
      end
      ST_VERIFY, ST_UPDATE: begin
`ifdef KEYTX_PACING_EN
        state_d = ST_GAP;
        ret_d   = ST_UNLOCKED;
`else
        go_done = 1'b1;
`endif
      end
      ST_UNLOCKED: begin
        if (ModeUpd) begin
          state_d    = ST_UPDATE;
          tx_bit_d   = ModeReq;
          tx_valid_d = 1'b1;
        end
      end
`ifdef KEYTX_PACING_EN
      ST_GAP: begin
        if (gap_done) begin
          go_send   = (ret_q == ST_SEND);
          go_verify = (ret_q == ST_VERIFY);
          go_done   = (ret_q == ST_UNLOCKED);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Next key/mode bit sits one below the MSB of the shift register
    if (go_send) begin
      state_d    = ST_SEND;
      shift_d    = shift_q << 1;
      cnt_d      = cnt_q + CNT_W'(1);
      tx_bit_d   = shift_q[SH_W-2];
      tx_valid_d = 1'b1;
    end
    if (go_verify) begin
      state_d    = ST_VERIFY;
      tx_bit_d   = 1'b0;
      tx_valid_d = 1'b1;
    end
    if (go_done) begin
      state_d    = ST_UNLOCKED;
      unlocked_d = 1'b1;
      done_d     = 1'b1;
    end

    busy_d = (state_d == ST_SEND) || (state_d == ST_VERIFY) ||
             (state_d == ST_UPDATE) || (state_d == ST_GAP);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      unlocked_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef KEYTX_PACING_EN
      ret_q      <= ST_IDLE;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      unlocked_q <= unlocked_d;
      done_q     <= done_d;
`ifdef KEYTX_PACING_EN
      ret_q      <= ret_d;
`endif
    end
  end

  assign TxBit    = tx_bit_q;
  assign TxValid  = tx_valid_q;
  assign Busy     = busy_q;
  assign Unlocked = unlocked_q;
  assign Done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_key_cmd_tx.sv
// ============================================================================
// tb_key_cmd_tx : table-driven bench with slot scoreboard and decoder model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_key_cmd_tx;
  import key_tx_pkg::*;

`ifdef KEYTX_PACING_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif

  logic Clk, Reset, Start, ModeReq, ModeUpd;
  logic TxBit, TxValid, Busy, Unlocked, Done;

  key_cmd_tx dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ModeReq  (ModeReq),
    .ModeUpd  (ModeUpd),
    .TxBit    (TxBit),
    .TxValid  (TxValid),
    .Busy     (Busy),
    .Unlocked (Unlocked),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit       start;
    bit       upd;
    bit       mreq;
    bit [1:0] acc;
    bit [4:0] exp;
  } vec_t;

  vec_t     tv[64];
  int       n_tv;
  int       n_vec = 0;
  int       n_bad = 0;
  bit       exp_q[$];
  bit [3:0] c_key = 4'b1010;

  bit       dec_active, dec_mode, dec_key_ok, dec_mode_pend;
  int       dec_idx;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_unlock(input bit m);
    for (int i = 0; i < KEY_W_DEF; i++) exp_q.push_back(c_key[KEY_W_DEF-1-i]);
    exp_q.push_back(m);
    exp_q.push_back(1'b0);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!Done && c < budget) begin
      tick();
      c++;
    end
    chk("done_seen", {4'd0, Done}, 5'd1);
  endtask

  // Slot scoreboard and receive-side decoder model
  initial begin
    bit e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        dec_active = 0; dec_mode = 0; dec_key_ok = 1; dec_mode_pend = 0; dec_idx = 0;
      end else if (TxValid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_slot: got unexpected TxValid slot (TxBit=%b) expected none", TxBit);
        end else begin
          e = exp_q.pop_front();
          if (TxBit !== e) begin
            n_bad++;
            $display("FAIL sb_slot: got TxBit=%b expected %b", TxBit, e);
          end
        end
        if (dec_active) begin
          dec_mode = TxBit;
        end else begin
          if (dec_idx < MODE_SLOT) begin
            if (TxBit != c_key[KEY_W_DEF-1-dec_idx]) dec_key_ok = 0;
          end else if (dec_idx == MODE_SLOT) begin
            dec_mode_pend = TxBit;
          end else begin
            dec_active = dec_key_ok;
            dec_mode   = dec_mode_pend;
          end
          dec_idx++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  useq[6];
    bit  vld, last;
    int  j, r;

    Reset = 1; Start = 0; ModeReq = 0; ModeUpd = 0;
    tick(); tick();
    chk("reset_state", {TxValid, TxBit, Busy, Unlocked, Done}, 5'b00000);
    Reset = 0;

    // ModeUpd while locked must be ignored
    ModeUpd = 1; ModeReq = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_modeupd_%0d", i), {3'd0, TxValid, Busy}, 5'd0);
    end
    ModeUpd = 0;

    // Abort after slot 2
    Start = 1; ModeReq = 0;
    push_unlock(1'b0);
    tick();
    Start = 0;
    repeat (2 * P) tick();
    @(negedge Clk); #1;
    chk("abort_left", 5'(exp_q.size()), 5'd3);
    exp_q.delete();
    Reset = 1;
    #1;
    chk("abort_outputs", {TxValid, TxBit, Busy, Unlocked, Done}, 5'b00000);
    tick(); tick();
    chk("abort_hold", {TxValid, TxBit, Busy, Unlocked, Done}, 5'b00000);
    Reset = 0;

    // Start and ModeUpd together from IDLE: unlock wins
    Start = 1; ModeUpd = 1; ModeReq = 1;
    push_unlock(1'b1);
    tick();
    Start = 0; ModeUpd = 0;
    wait_done(12 * P + 4);
    chk("restart_unl", {3'd0, Unlocked, Busy}, 5'b00010);
    chk("restart_sb", 5'(exp_q.size()), 5'd0);
    chk("restart_dec", {3'd0, dec_active, dec_mode}, 5'b00011);

    Reset = 1;
    tick(); tick();
    Reset = 0;

    // Vector table: unlock, ignored Starts, then continuous alternating updates
    useq = '{1, 0, 1, 0, 1, 0};
    n_tv = 0;
    last = 0;
    for (int k = 1; k <= 6 * P + 2; k++) begin
      tv[n_tv].start = (k == 1) || (k == 3) || (k == 6 * P + 2);
      tv[n_tv].upd   = 0;
      tv[n_tv].mreq  = (k == 1);
      tv[n_tv].acc   = (k == 1) ? 2'd1 : 2'd0;
      vld = (k <= 6 * P) && ((k - 1) % P == 0);
      if (vld) last = useq[(k - 1) / P][0];
      tv[n_tv].exp = {vld, last, k <= 6 * P, k > 6 * P, k == 6 * P + 1};
      n_tv++;
    end
    for (int t = 0; t < 4 * (P + 1); t++) begin
      j = t / (P + 1);
      r = t % (P + 1);
      tv[n_tv].start = 0;
      tv[n_tv].upd   = 1;
      tv[n_tv].mreq  = j[0];
      tv[n_tv].acc   = (r == 0) ? 2'd2 : 2'd0;
      vld = (r == 0);
      if (vld) last = j[0];
      tv[n_tv].exp = {vld, last, r < P, 1'b1, r == P};
      n_tv++;
    end
    tv[n_tv].start = 0; tv[n_tv].upd = 0; tv[n_tv].mreq = 0; tv[n_tv].acc = 0;
    tv[n_tv].exp = {1'b0, last, 1'b0, 1'b1, 1'b0};
    n_tv++;

    for (int v = 0; v < n_tv; v++) begin
      Start = tv[v].start; ModeUpd = tv[v].upd; ModeReq = tv[v].mreq;
      if (tv[v].acc == 2'd1) push_unlock(tv[v].mreq);
      else if (tv[v].acc == 2'd2) exp_q.push_back(tv[v].mreq);
      tick();
      chk($sformatf("vec_%0d", v), {TxValid, TxBit, Busy, Unlocked, Done}, tv[v].exp);
      if (v == 6 * P) chk("dec_unlock", {3'd0, dec_active, dec_mode}, 5'b00011);
      if (v == 6 * P + 2 + P) chk("dec_update0", {3'd0, dec_active, dec_mode}, 5'b00010);
    end
    chk("final_sb", 5'(exp_q.size()), 5'd0);
    chk("final_dec", {3'd0, dec_active, dec_mode}, 5'b00011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
